// File: rtl/rtc_ctrl_pkg.sv
// Shared types and limits for the RTC time/set controller.
// The state enum doubles as the edit_field encoding.
package rtc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } rtc_state_e;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  function automatic logic [5:0] wrap_inc(
    input logic [5:0] v,
    input logic [5:0] max
  );
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/hms_counter.sv
// Live hour/minute/second registers.
// Ticks carry through the chain; set-path increments wrap locally.
module hms_counter
  import rtc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       inc_hour_i,
  input  logic       inc_min_i,
  input  logic       clr_sec_i,
  output logic [4:0] hour_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o
);

  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [4:0] hour_nx;
  logic [5:0] min_nx;
  logic [5:0] sec_nx;

  always_comb begin
    hour_nx = 5'(wrap_inc({1'b0, hour_q}, {1'b0, MAX_HOUR}));
    min_nx  = wrap_inc(min_q, MAX_MIN);
    sec_nx  = wrap_inc(sec_q, MAX_SEC);
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    unique case (1'b1)
      tick_i: begin
        sec_d = sec_nx;
        if (sec_q == MAX_SEC) begin
          min_d = min_nx;
          if (min_q == MAX_MIN)
            hour_d = hour_nx;
        end
      end
      inc_hour_i: hour_d = hour_nx;
      inc_min_i:  min_d  = min_nx;
      clr_sec_i:  sec_d  = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
    end
  end

  assign hour_o = hour_q;
  assign min_o  = min_q;
  assign sec_o  = sec_q;

endmodule

// File: rtl/rtc_time_ctrl.sv
// RTC controller: set-mode FSM, 1 Hz prescaler, blink divider
// and frame-synchronous shadow registers for the overlay renderer.
module rtc_time_ctrl
  import rtc_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 27_000_000,
  parameter int BLINK_DIV = 13_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       frame_start,
  output logic [4:0] hour_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  rtc_state_e    state_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          tick_q;
  logic [4:0]    hour_q;
  logic [5:0]    min_q;
  logic [5:0]    sec_q;
  logic [1:0]    edit_q;
  logic          blink_q;

  logic       tick;
  logic       live_blink;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic       set_ok;
  logic [4:0] live_hour;
  logic [5:0] live_min;
  logic [5:0] live_sec;

  always_comb begin
    tick       = (state_q == RUN) && (presc_q == PRESC_TC);
    live_blink = (state_q != RUN) && phase_q;
    set_ok     = btn_inc && !btn_mode;
    inc_hour   = set_ok && (state_q == SET_HOUR);
    inc_min    = set_ok && (state_q == SET_MIN);
    clr_sec    = set_ok && (state_q == SET_SEC);
    // Held at zero outside RUN so a resumed clock waits a full second.
    presc_d = '0;
    if ((state_q == RUN) && !btn_mode && !tick)
      presc_d = presc_q + PW'(1);
    bcnt_d  = (bcnt_q == BLINK_TC) ? '0 : bcnt_q + BW'(1);
    phase_d = phase_q ^ (bcnt_q == BLINK_TC);
  end

  hms_counter u_hms (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .inc_hour_i (inc_hour),
    .inc_min_i  (inc_min),
    .clr_sec_i  (clr_sec),
    .hour_o     (live_hour),
    .min_o      (live_min),
    .sec_o      (live_sec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else if (btn_mode) begin
      unique case (state_q)
        RUN:      state_q <= SET_HOUR;
        SET_HOUR: state_q <= SET_MIN;
        SET_MIN:  state_q <= SET_SEC;
        SET_SEC:  state_q <= RUN;
        default:  state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      tick_q  <= tick;
    end
  end

  // Shadow takes pre-edge live values, so digits only move per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      edit_q  <= '0;
      blink_q <= 1'b0;
    end else if (frame_start) begin
      hour_q  <= live_hour;
      min_q   <= live_min;
      sec_q   <= live_sec;
      edit_q  <= state_q;
      blink_q <= live_blink;
    end
  end

  assign hour_o     = hour_q;
  assign min_o      = min_q;
  assign sec_o      = sec_q;
  assign edit_field = edit_q;
  assign blink      = blink_q;
  assign tick_1hz   = tick_q;

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Self-checking bench for rtc_time_ctrl: directed tables, corner
// sequences, and random stimulus against a time-of-day model.
module tb_rtc_time_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int BLINK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic       frame_start;
  logic [4:0] hour_o;
  logic [5:0] min_o;
  logic [5:0] sec_o;
  logic [1:0] edit_field;
  logic       blink;
  logic       tick_1hz;

  int total = 0;
  int bad   = 0;

  rtc_time_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .frame_start (frame_start),
    .hour_o      (hour_o),
    .min_o       (min_o),
    .sec_o       (sec_o),
    .edit_field  (edit_field),
    .blink       (blink),
    .tick_1hz    (tick_1hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time of day as seconds since midnight.
  int m_tod, m_mode, m_run, m_edges;
  int sh_h, sh_m, sh_s, sh_f;
  bit sh_b, m_tick;
  int mh, mm, ms;
  bit lb, tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tod = 0; m_mode = 0; m_run = 0; m_edges = 0;
      sh_h = 0; sh_m = 0; sh_s = 0; sh_f = 0;
      sh_b = 0; m_tick = 0;
    end else begin
      lb = (m_mode != 0) && (((m_edges / BLINK_DIV) % 2) == 1);
      tk = (m_mode == 0) && (m_run == CLK_HZ - 1);
      if (frame_start) begin
        sh_h = m_tod / 3600;
        sh_m = (m_tod / 60) % 60;
        sh_s = m_tod % 60;
        sh_f = m_mode;
        sh_b = lb;
      end
      m_tick = tk;
      if (tk) m_tod = (m_tod + 1) % 86400;
      m_run = (m_mode == 0 && !btn_mode && !tk) ? m_run + 1 : 0;
      mh = m_tod / 3600;
      mm = (m_tod / 60) % 60;
      ms = m_tod % 60;
      if (btn_mode) m_mode = (m_mode + 1) % 4;
      else if (btn_inc) begin
        case (m_mode)
          1: mh = (mh + 1) % 24;
          2: mm = (mm + 1) % 60;
          3: ms = 0;
          default: ;
        endcase
      end
      m_tod = mh * 3600 + mm * 60 + ms;
      m_edges++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge; return at the next negedge.
  task automatic step(input bit m, input bit i, input bit f);
    btn_mode = m;
    btn_inc = i;
    frame_start = f;
    @(negedge clk);
    btn_mode = 0;
    btn_inc = 0;
    frame_start = 0;
  endtask

  task automatic chk_time(input string nm, input int h, input int mi,
                          input int s, input int f);
    chk({nm, "_hour"}, hour_o, h);
    chk({nm, "_min"}, min_o, mi);
    chk({nm, "_sec"}, sec_o, s);
    chk({nm, "_field"}, edit_field, f);
  endtask

  typedef struct {
    bit mode;
    int n_inc;
    int h;
    int mi;
    int s;
    int f;
  } vec_t;

  vec_t vecs[4];
  int   ticks;
  bit   found;
  int   exp_v;
  int   act_v;

  initial begin
    rst_n = 0;
    btn_mode = 0;
    btn_inc = 0;
    frame_start = 0;
    vecs[0] = '{1, 5, 5, 0, 12, 1};
    vecs[1] = '{1, 30, 5, 30, 12, 2};
    vecs[2] = '{1, 1, 5, 30, 0, 3};
    vecs[3] = '{1, 0, 5, 30, 0, 0};

    repeat (3) @(negedge clk);
    chk_time("reset", 0, 0, 0, 0);
    chk("reset_blink", blink, 0);
    chk("reset_tick", tick_1hz, 0);
    rst_n = 1;

    // 100 cycles of free run from reset
    ticks = 0;
    repeat (100) begin
      step(0, 0, 0);
      if (tick_1hz) ticks++;
    end
    chk("run_ticks", ticks, 10);
    step(0, 0, 1);
    chk_time("run100", 0, 0, 10, 0);

    // Tick without frame leaves outputs alone
    found = 0;
    for (int k = 0; k < 2 * CLK_HZ && !found; k++) begin
      step(0, 0, 0);
      if (tick_1hz) found = 1;
    end
    chk("shadow_tick_seen", found, 1);
    chk("shadow_hold", sec_o, 10);
    repeat (CLK_HZ - 1) step(0, 0, 0);
    step(0, 0, 1);
    chk("shadow_coinc_tick", tick_1hz, 1);
    chk("shadow_coinc_old", sec_o, 11);
    step(0, 0, 1);
    chk("shadow_next_new", sec_o, 12);

    // Set sequence
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].mode) step(1, 0, 0);
      repeat (vecs[v].n_inc) step(0, 1, 0);
      step(0, 0, 1);
      chk_time($sformatf("setvec%0d", v), vecs[v].h, vecs[v].mi,
               vecs[v].s, vecs[v].f);
    end
    for (int k = 2; k <= CLK_HZ; k++) begin
      step(0, 0, 0);
      chk($sformatf("resume_tick_k%0d", k), tick_1hz, (k == CLK_HZ) ? 1 : 0);
    end

    // Simultaneous buttons: mode wins
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    chk_time("simul", 7, 30, 1, 2);

    // Async reset while editing with blink shown
    found = 0;
    for (int k = 0; k < 2 * BLINK_DIV + 4 && !found; k++) begin
      step(0, 0, 1);
      if (blink) found = 1;
    end
    chk("edit_blink_seen", found, 1);
    chk("edit_blink_field", edit_field, 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk_time("async_rst", 0, 0, 0, 0);
    chk("async_rst_blink", blink, 0);
    chk("async_rst_tick", tick_1hz, 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 1);
    chk_time("post_rst", 0, 0, 0, 0);
    chk("post_rst_blink", blink, 0);

    // Rollover: 59 ticks, then set 23:59
    ticks = 0;
    for (int k = 0; k < 60 * CLK_HZ && ticks < 59; k++) begin
      step(0, 0, 0);
      if (tick_1hz) ticks++;
    end
    chk("roll_ticks", ticks, 59);
    step(1, 0, 0);
    repeat (23) step(0, 1, 0);
    step(1, 0, 0);
    repeat (59) step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    chk_time("roll_pre", 23, 59, 59, 0);
    found = 0;
    for (int k = 0; k < 2 * CLK_HZ && !found; k++) begin
      step(0, 0, 0);
      if (tick_1hz) found = 1;
    end
    chk("roll_tick_seen", found, 1);
    step(0, 0, 1);
    chk_time("roll_post", 0, 0, 0, 0);

    // Random stimulus against the model
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);
      exp_v = {sh_h[4:0], sh_m[5:0], sh_s[5:0], sh_f[1:0], sh_b, m_tick};
      act_v = {hour_o, min_o, sec_o, edit_field, blink, tick_1hz};
      chk($sformatf("rand%0d", n), act_v, exp_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
